// File: rtl/bcd2bin_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic digit_valid(input logic [BCD_DIGIT_W-1:0] digit);
    return digit <= 4'd9;
  endfunction

  // Smallest w with 2**w >= 10**n, i.e. ceil(log2(10**n)).
  function automatic int unsigned bin_width(input int unsigned n);
    longint unsigned pow10;
    pow10 = 64'd1;
    for (int unsigned i = 0; i < n; i++) pow10 = pow10 * 64'd10;
    for (int unsigned w = 0; w < 64; w++) begin
      if ((64'd1 << w) >= pow10) return w;
    end
    return 64;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble correction: subtract 3 from a digit that is 8 or more.
module bcd_digit_adjust
  import bcd2bin_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = i_digit[3] ? i_digit - 4'd3 : i_digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one step per cycle.
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int unsigned N_DIGITS = 2,
  parameter int unsigned BIN_W    = 7
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [BCD_DIGIT_W*N_DIGITS-1:0] bcd,
  output logic                            ready,
  output logic                            done_tick,
  output logic [BIN_W-1:0]                bin,
  output logic                            err
);

  localparam int unsigned D_W   = BCD_DIGIT_W * N_DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W);

  if (N_DIGITS < 1 || N_DIGITS > 9) begin : g_bad_digits
    $error("N_DIGITS must be in 1..9");
  end
  if (BIN_W != bin_width(N_DIGITS)) begin : g_bad_width
    $error("BIN_W must equal ceil(log2(10**N_DIGITS))");
  end

  state_e           r_state, w_state_next;
  logic [D_W-1:0]   r_d, w_d_next, w_d_shift, w_d_adj;
  logic [BIN_W-1:0] r_b, w_b_next, w_b_shift;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [BIN_W-1:0] r_bin, w_bin_next;
  logic             r_ready, w_ready_next;
  logic             r_done, w_done_next;
  logic             r_err, w_err_next;
  logic             w_bcd_ok;

  always_comb begin
    w_bcd_ok = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (!digit_valid(bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W])) w_bcd_ok = 1'b0;
    end
  end

  assign {w_d_shift, w_b_shift} = {r_d, r_b} >> 1;

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit(w_d_shift[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit(w_d_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    w_state_next = r_state;
    w_d_next     = r_d;
    w_b_next     = r_b;
    w_cnt_next   = r_cnt;
    w_bin_next   = r_bin;
    w_err_next   = r_err;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_d_next     = bcd;
          w_b_next     = '0;
          w_cnt_next   = '0;
          w_err_next   = !w_bcd_ok;
          if (!w_bcd_ok) w_bin_next = '0;
          w_state_next = OP;
        end
      end
      OP: begin
        // A rejected operand spends one idle cycle here so its report always lands two cycles out.
        if (r_err) begin
          w_state_next = DONE;
        end else begin
          w_d_next   = w_d_adj;
          w_b_next   = w_b_shift;
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == CNT_W'(BIN_W - 1)) begin
            w_bin_next   = w_b_shift;
            w_state_next = DONE;
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    w_ready_next = (w_state_next == IDLE);
    w_done_next  = (w_state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_d     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_d     <= w_d_next;
      r_b     <= w_b_next;
      r_cnt   <= w_cnt_next;
      r_bin   <= w_bin_next;
      r_ready <= w_ready_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  assign ready     = r_ready;
  assign done_tick = r_done;
  assign bin       = r_bin;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Randomised and directed bench for bcd2bin_seq against a decimal arithmetic model.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        reset_n, start, start3;
  logic [7:0]  bcd;
  logic [11:0] bcd3;
  logic        ready, done_tick, err;
  logic [6:0]  bin;
  logic        ready3, done3, err3;
  logic [9:0]  bin3;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] b2b_ops [4] = '{8'h00, 8'h55, 8'h09, 8'h90};

  always #5 clk = ~clk;

  bcd2bin_seq #(.N_DIGITS(2), .BIN_W(7)) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bcd      (bcd),
    .ready    (ready),
    .done_tick(done_tick),
    .bin      (bin),
    .err      (err)
  );

  bcd2bin_seq #(.N_DIGITS(3), .BIN_W(10)) u_dut3 (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start3),
    .bcd      (bcd3),
    .ready    (ready3),
    .done_tick(done3),
    .bin      (bin3),
    .err      (err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: decimal value of the digits; any digit above 9 makes the operand invalid.
  function automatic void ref_conv(input logic [11:0] op, input int ndig,
                                   output int val, output bit bad);
    int d;
    val = 0;
    bad = 1'b0;
    for (int i = ndig - 1; i >= 0; i--) begin
      d = int'((op >> (4 * i)) & 12'hF);
      if (d > 9) bad = 1'b1;
      val = val * 10 + d;
    end
    if (bad) val = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit three);
    for (int k = 0; k < 30; k++) begin
      if (three ? ready3 : ready) break;
      tick();
    end
    check(three ? "ready3_wait" : "ready_wait", three ? ready3 : ready, 1);
  endtask

  // Cycle 1 is the cycle right after the accept edge.
  task automatic run2(input logic [7:0] op, input bit hold, input logic [7:0] alt,
                      input string tag);
    int val, cyc;
    bit bad, seen;
    ref_conv({4'h0, op}, 2, val, bad);
    wait_ready(1'b0);
    start = 1'b1;
    bcd   = op;
    tick();
    check({tag, "_ready_low"}, ready, 0);
    if (!hold) start = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done_tick) begin
        seen = 1'b1;
        break;
      end
      tick();
      cyc++;
      if (hold && cyc == 4) begin
        bcd   = alt;
        start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_latency"}, cyc, bad ? 2 : 8);
      check({tag, "_bin"}, bin, val);
      check({tag, "_err"}, err, bad);
      tick();
      check({tag, "_done_pulse"}, done_tick, 0);
      check({tag, "_ready_back"}, ready, 1);
    end
  endtask

  task automatic run3(input logic [11:0] op, input string tag);
    int val, cyc;
    bit bad, seen;
    ref_conv(op, 3, val, bad);
    wait_ready(1'b1);
    start3 = 1'b1;
    bcd3   = op;
    tick();
    start3 = 1'b0;
    check({tag, "_ready_low"}, ready3, 0);
    cyc  = 1;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (done3) begin
        seen = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_latency"}, cyc, bad ? 2 : 11);
      check({tag, "_bin"}, bin3, val);
      check({tag, "_err"}, err3, bad);
    end
  endtask

  task automatic back_to_back();
    int val, idx, last, cyc;
    bit bad;
    idx  = 0;
    last = 0;
    cyc  = 0;
    wait_ready(1'b0);
    start = 1'b1;
    bcd   = b2b_ops[0];
    for (int k = 0; k < 60 && idx < 4; k++) begin
      tick();
      cyc++;
      if (done_tick) begin
        ref_conv({4'h0, b2b_ops[idx]}, 2, val, bad);
        check($sformatf("b2b%0d_bin", idx), bin, val);
        check($sformatf("b2b%0d_err", idx), err, bad);
        if (idx == 0) check("b2b_first_latency", cyc, 8);
        else check($sformatf("b2b%0d_gap", idx), cyc - last, 9);
        last = cyc;
        idx++;
        if (idx < 4) bcd = b2b_ops[idx];
        else start = 1'b0;
      end
    end
    start = 1'b0;
    check("b2b_count", idx, 4);
  endtask

  task automatic reset_mid_op();
    int pulses;
    wait_ready(1'b0);
    start = 1'b1;
    bcd   = 8'h77;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("rst_ready", ready, 1);
    check("rst_bin", bin, 0);
    check("rst_done", done_tick, 0);
    reset_n = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 15; k++) begin
      if (done_tick) pulses++;
      tick();
    end
    check("rst_no_done", pulses, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rop;
    logic [11:0] rop3;
    reset_n = 1'b0;
    start   = 1'b0;
    bcd     = '0;
    start3  = 1'b0;
    bcd3    = '0;
    tick();
    tick();
    check("reset_ready", ready, 1);
    check("reset_done", done_tick, 0);
    check("reset_bin", bin, 0);
    check("reset_err", err, 0);
    check("reset_ready3", ready3, 1);
    check("reset_bin3", bin3, 0);
    reset_n = 1'b1;
    tick();

    run2(8'h99, 1'b0, 8'h00, "op99");
    back_to_back();
    run2(8'hA5, 1'b0, 8'h00, "opA5");
    run2(8'h42, 1'b0, 8'h00, "op42");
    reset_mid_op();
    run2(8'h13, 1'b0, 8'h00, "op13");
    run2(8'h12, 1'b1, 8'h98, "midop");

    for (int i = 0; i < 24; i++) begin
      rop = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      run2(rop, 1'b0, 8'h00, $sformatf("rnd%0d", i));
    end

    run3(12'h999, "w3_999");
    run3(12'h100, "w3_100");
    for (int i = 0; i < 8; i++) begin
      rop3 = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10))};
      run3(rop3, $sformatf("w3_rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
